// File: rtl/alu_arbiter.sv
// Two-requester ALU front end: arbitrates between req0/req1 with a
// rotating priority pointer, executes one operation at a time and
// returns the result through a valid/ready response port.
module alu_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_op,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_id,
  output logic        busy,
  output logic [15:0] op_count
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned OP_W    = 3;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned COUNT_W = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_OR  = 3'b010;
  localparam logic [OP_W-1:0] OP_SLT = 3'b011;
  localparam logic [OP_W-1:0] OP_AND = 3'b100;
  localparam logic [OP_W-1:0] OP_XOR = 3'b101;
  localparam logic [OP_W-1:0] OP_SLL = 3'b110;
  localparam logic [OP_W-1:0] OP_SRL = 3'b111;

  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic              prio;
  logic              grant_valid;
  logic              grant_id;
  logic [DATA_W-1:0] cap_a;
  logic [DATA_W-1:0] cap_b;
  logic [OP_W-1:0]   cap_op;
  logic              cap_id;
  logic [DATA_W-1:0] alu_result;
  logic [SHAMT_W-1:0] shamt;

  // Grant selection: only meaningful in IDLE; prio breaks ties
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (state == ST_IDLE) begin
      if (req0_valid && req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = prio;
      end else if (req0_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b0;
      end else if (req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b1;
      end
    end
  end

  assign req0_ready = grant_valid && !grant_id;
  assign req1_ready = grant_valid &&  grant_id;
  assign resp_valid = (state == ST_RESP);
  assign busy       = (state != ST_IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (grant_valid) state_next = ST_EXEC;
      ST_EXEC: state_next = ST_RESP;
      ST_RESP: if (resp_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // ALU on the captured operands
  always_comb begin
    shamt      = cap_b[SHAMT_W-1:0];
    alu_result = '0;
    case (cap_op)
      OP_ADD: alu_result = cap_a + cap_b;
      OP_SUB: alu_result = cap_a - cap_b;
      OP_OR:  alu_result = cap_a | cap_b;
      OP_SLT: alu_result = DATA_W'(cap_a < cap_b);
      OP_AND: alu_result = cap_a & cap_b;
      OP_XOR: alu_result = cap_a ^ cap_b;
      OP_SLL: alu_result = cap_a << shamt;
      OP_SRL: alu_result = cap_a >> shamt;
      default: alu_result = '0;
    endcase
  end

  // Operand capture, priority rotation, response and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      prio      <= 1'b0;
      cap_a     <= '0;
      cap_b     <= '0;
      cap_op    <= '0;
      cap_id    <= 1'b0;
      resp_data <= '0;
      resp_id   <= 1'b0;
      op_count  <= '0;
    end else begin
      if (grant_valid) begin
        cap_a  <= grant_id ? req1_a  : req0_a;
        cap_b  <= grant_id ? req1_b  : req0_b;
        cap_op <= grant_id ? req1_op : req0_op;
        cap_id <= grant_id;
        prio   <= !grant_id;
      end
      if (state == ST_EXEC) begin
        resp_data <= alu_result;
        resp_id   <= cap_id;
      end
      if ((state == ST_RESP) && resp_ready && (op_count != COUNT_MAX)) begin
        op_count <= op_count + COUNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter.
module tb_alu_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid, req0_ready;
  logic [31:0] req0_a, req0_b;
  logic [2:0]  req0_op;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_a, req1_b;
  logic [2:0]  req1_op;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data;
  logic        resp_id;
  logic        busy;
  logic [15:0] op_count;

  int errors = 0;
  int checks = 0;

  logic [31:0] sweep_exp [8];

  alu_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .busy       (busy),
    .op_count   (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    sweep_exp[0] = 32'h0000_0000;
    sweep_exp[1] = 32'hFFFF_FFFE;
    sweep_exp[2] = 32'hFFFF_FFFF;
    sweep_exp[3] = 32'h0000_0000;
    sweep_exp[4] = 32'h0000_0001;
    sweep_exp[5] = 32'hFFFF_FFFE;
    sweep_exp[6] = 32'hFFFF_FFFE;
    sweep_exp[7] = 32'h7FFF_FFFF;

    rst = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    resp_ready = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data",  resp_data,       32'd0);
    check("rst_resp_id",    32'(resp_id),    32'd0);
    check("rst_op_count",   32'(op_count),   32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_req0_ready", 32'(req0_ready), 32'd0);
    check("rst_req1_ready", 32'(req1_ready), 32'd0);
    rst = 1'b0;

    // Single op: 5 - 3
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_op = 3'b001;
    resp_ready = 1'b1;
    #1;
    check("single_req0_ready_c0", 32'(req0_ready), 32'd1);
    check("single_req1_ready_c0", 32'(req1_ready), 32'd0);
    tick();
    req0_valid = 1'b0;
    #1;
    check("single_busy_c1",       32'(busy),       32'd1);
    check("single_resp_valid_c1", 32'(resp_valid), 32'd0);
    check("single_req0_ready_c1", 32'(req0_ready), 32'd0);
    tick();
    check("single_resp_valid_c2", 32'(resp_valid), 32'd1);
    check("single_resp_data",     resp_data,       32'd2);
    check("single_resp_id",       32'(resp_id),    32'd0);
    tick();
    check("single_resp_valid_c3", 32'(resp_valid), 32'd0);
    check("single_busy_c3",       32'(busy),       32'd0);
    check("single_op_count",      32'(op_count),   32'd1);

    // Contention from a fresh reset: grants alternate starting with req0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_op = 3'b000;
    req1_valid = 1'b1; req1_a = 32'd2; req1_b = 32'd2; req1_op = 3'b000;
    resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("cont%0d_req0_ready", k), 32'(req0_ready), 32'((k % 2) == 0));
      check($sformatf("cont%0d_req1_ready", k), 32'(req1_ready), 32'((k % 2) == 1));
      tick();
      tick();
      check($sformatf("cont%0d_resp_valid", k), 32'(resp_valid), 32'd1);
      check($sformatf("cont%0d_resp_data", k),  resp_data, ((k % 2) == 0) ? 32'd2 : 32'd4);
      check($sformatf("cont%0d_resp_id", k),    32'(resp_id), 32'(k % 2));
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("cont_op_count", 32'(op_count), 32'd4);

    // Backpressure: 1 << 4 held in RESP while resp_ready is low
    req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'h24; req1_op = 3'b110;
    resp_ready = 1'b0;
    #1;
    check("bp_req1_ready_accept", 32'(req1_ready), 32'd1);
    tick();
    req1_a = 32'hDEAD_BEEF;
    req0_valid = 1'b1;
    tick();
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp%0d_resp_valid", c), 32'(resp_valid), 32'd1);
      check($sformatf("bp%0d_resp_data", c),  resp_data, 32'h10);
      check($sformatf("bp%0d_resp_id", c),    32'(resp_id), 32'd1);
      check($sformatf("bp%0d_req0_ready", c), 32'(req0_ready), 32'd0);
      check($sformatf("bp%0d_req1_ready", c), 32'(req1_ready), 32'd0);
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    resp_ready = 1'b1;
    tick();
    check("bp_done_resp_valid", 32'(resp_valid), 32'd0);
    check("bp_done_busy",       32'(busy),       32'd0);
    check("bp_hold_resp_data",  resp_data,       32'h10);
    check("bp_op_count",        32'(op_count),   32'd5);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    check("bp_prio_req0_ready", 32'(req0_ready), 32'd1);
    check("bp_prio_req1_ready", 32'(req1_ready), 32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;

    // Opcode sweep with a=all-ones, b=1
    req0_a = 32'hFFFF_FFFF; req0_b = 32'd1;
    for (int op = 0; op < 8; op++) begin
      req0_op = 3'(op);
      req0_valid = 1'b1;
      #1;
      tick();
      req0_valid = 1'b0;
      tick();
      check($sformatf("sweep_op%0d", op), resp_data, sweep_exp[op]);
      tick();
    end
    check("sweep_op_count", 32'(op_count), 32'd13);

    // Reset during EXEC discards the operation
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_op = 3'b000;
    #1;
    tick();
    req0_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_exec_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_exec_busy",       32'(busy),       32'd0);
    check("rst_exec_op_count",   32'(op_count),   32'd0);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    check("rst_exec_prio_req0", 32'(req0_ready), 32'd1);
    check("rst_exec_prio_req1", 32'(req1_ready), 32'd0);

    // Reset wins over a simultaneous response handshake
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    check("rst_resp_pre_valid", 32'(resp_valid), 32'd1);
    resp_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_resp_valid_after", 32'(resp_valid), 32'd0);
    check("rst_resp_op_count",    32'(op_count),   32'd0);
    check("rst_resp_data_clear",  resp_data,       32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have no parameters; all widths fixed (data 32, op 3, id 1, count 16).
REQ-002 SHALL provide ports, clock and reset first:
  clk  input  1  sole clock, all state updates on rising edge
  rst  input  1  synchronous reset, active-high
  req0_valid  input  1  requester 0 has an operation
  req0_ready  output 1  requester 0 operation accepted this cycle when valid&ready
  req0_a, req0_b  input  32 each  requester 0 operands
  req0_op  input  3  requester 0 opcode
  req1_valid / req1_ready / req1_a / req1_b / req1_op  same as requester 0, for requester 1
  resp_valid  output 1  result available
  resp_ready  input  1  consumer takes result when valid&ready
  resp_data  output 32  result
  resp_id  output 1  requester that issued the result (0 or 1)
  busy  output 1  high whenever state is not IDLE
  op_count  output 16  completed-operation counter
REQ-003 Reset SHALL be synchronous and active-high on clk; no asynchronous reset path.

Function
REQ-004 SHALL implement FSM with states IDLE, EXEC, RESP; one operation outstanding at a time.
REQ-005 Opcode map, result width 32: 000 A+B; 001 A-B; 010 A|B; 011 (A<B unsigned)?1:0; 100 A&B; 101 A^B; 110 A<<B[4:0]; 111 A>>B[4:0] logical; add/sub wrap modulo 2^32, no carry/overflow flag.
REQ-006 Grant (combinational, IDLE only): only one valid -> that requester; both valid -> requester named by priority pointer prio; neither -> no grant.
REQ-007 reqN_ready SHALL be 1 only when state==IDLE and requester N granted; both readies never 1 together; ready never depends on resp_ready.
REQ-008 On acceptance in IDLE: capture a, b, op, id into internal registers; prio <= id of the requester not granted; state -> EXEC.
REQ-009 prio SHALL change only on acceptance; single-requester grants also update it (prio points away from last winner).
REQ-010 In EXEC: compute per REQ-005 from captured registers; resp_data <= result, resp_id <= captured id; state -> RESP. Exactly one cycle in EXEC.
REQ-011 In RESP: resp_valid=1; resp_data and resp_id stable until handshake; on resp_ready=1 -> IDLE, op_count increments.
REQ-012 resp_valid SHALL be 1 only in RESP; resp_data/resp_id hold last value outside RESP.
REQ-013 Latency: acceptance at edge N -> resp_valid high from cycle N+2; with resp_ready held high, next acceptance no earlier than cycle N+3 (throughput 1 op / 3 cycles).
REQ-014 Backpressure: resp_ready low holds RESP indefinitely; requests remain unaccepted (ready=0) meanwhile.
REQ-015 Requester inputs change while not accepted SHALL have no effect; captured operands immune to later input changes.
REQ-016 op_count SHALL saturate at 16'hFFFF (no wrap).
REQ-017 busy = (state != IDLE).

Reset
REQ-018 rst=1 at an edge SHALL force: state IDLE, prio=0, resp_valid=0, resp_data=0, resp_id=0, op_count=0, busy=0, both readies evaluate from IDLE/prio=0.
REQ-019 Reset mid-operation (EXEC or RESP) SHALL discard the operation; no response emitted, op_count not incremented.
REQ-020 rst SHALL take precedence over any simultaneous handshake at the same edge.

Verification
REQ-021 Single op: req0 valid, a=5, b=3, op=001, resp_ready=1 -> req0_ready=1 cycle 0; resp_valid cycle 2 with resp_data=2, resp_id=0; op_count=1.
REQ-022 Contention: both valid continuously after reset, op=000 (req0 1+1, req1 2+2) -> grants alternate 0,1,0,1; results 2,4,2,4 with matching resp_id.
REQ-023 Backpressure: req1 op=110 a=1 b=0x24 (shift 4), resp_ready=0 for 5 cycles -> resp_valid held, resp_data=0x10 stable, both readies 0, then completes on resp_ready=1.
REQ-024 Opcode sweep: a=0xFFFFFFFF, b=1 across all 8 ops -> 0, 0xFFFFFFFE, 0xFFFFFFFF, 0, 1, 0xFFFFFFFE, 0xFFFFFFFE, 0x7FFFFFFF.
REQ-025 Reset mid-op: accept req0, assert rst during EXEC -> next cycle resp_valid=0, busy=0, op_count unchanged (0), prio=0.
